// File: rtl/trigger_event_stamper_pkg.sv
`default_nettype none
// ============================================================================
// Module      : trigger_event_stamper_pkg
// Description : Shared event-source codes, sequencer states and record sizing
//               for the trigger event stamper.
// Revision    : 1.0 - initial release
// ============================================================================
package trigger_event_stamper_pkg;

  localparam int SRC_WIDTH = 2;
  localparam int TOF_WIDTH = 32;

  localparam logic [SRC_WIDTH-1:0] EVT_SRC_TMO  = 2'b00;
  localparam logic [SRC_WIDTH-1:0] EVT_SRC_T0   = 2'b01;
  localparam logic [SRC_WIDTH-1:0] EVT_SRC_T1   = 2'b10;
  localparam logic [SRC_WIDTH-1:0] EVT_SRC_BOTH = 2'b11;

  typedef enum logic [1:0] {
    SEQ_DISARMED = 2'd0,
    SEQ_WAIT_T0  = 2'd1,
    SEQ_WAIT_T1  = 2'd2,
    SEQ_COMPLETE = 2'd3
  } seq_state_t;

  // Record layout is {src, ts, tof}, MSB first
  function automatic int rec_width(input int ts_width);
    return SRC_WIDTH + ts_width + TOF_WIDTH;
  endfunction

endpackage
`default_nettype wire

// File: rtl/trigger_event_stamper_if.sv
`default_nettype none
// ============================================================================
// Module      : trigger_event_stamper_if
// Description : Valid/ready event-record stream from the stamper to the host.
// Revision    : 1.0 - initial release
// ============================================================================
interface trigger_event_stamper_if #(
  parameter int TS_WIDTH = 48
);
  logic                evt_valid;
  logic                evt_ready;
  logic [1:0]          evt_src;
  logic [TS_WIDTH-1:0] evt_ts;
  logic [31:0]         evt_tof;

  modport master (
    output evt_valid,
    output evt_src,
    output evt_ts,
    output evt_tof,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_src,
    input  evt_ts,
    input  evt_tof,
    output evt_ready
  );
endinterface
`default_nettype wire

// File: rtl/trigger_event_stamper_evt_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : evt_sync_fifo
// Description : First-word-fall-through FIFO with combinational read, flush,
//               and a held copy of the last popped word for the empty case.
// Revision    : 1.0 - initial release
// ============================================================================
module evt_sync_fifo #(
  parameter int WIDTH = 82,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  output logic                     full,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int c_PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_PTR_W:0]   r_level;
  logic [WIDTH-1:0]   r_last;
  logic               w_do_push;
  logic               w_do_pop;

  assign full      = (r_level == (c_PTR_W+1)'(DEPTH));
  assign empty     = (r_level == '0);
  assign level     = r_level;
  // A full FIFO drops the incoming word even when a pop frees a slot this cycle
  assign w_do_push = push & ~full & ~flush;
  assign w_do_pop  = pop & ~empty & ~flush;
  assign rd_data   = empty ? r_last : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_last   <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_last   <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
        r_last   <= r_mem[r_rd_ptr];
      end
      if (w_do_push && !w_do_pop) begin
        r_level <= r_level + (c_PTR_W+1)'(1);
      end else if (!w_do_push && w_do_pop) begin
        r_level <= r_level - (c_PTR_W+1)'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/trigger_event_stamper.sv
`default_nettype none
// ============================================================================
// Module      : trigger_event_stamper
// Description : Timestamps trigger0/trigger1 rising edges with pulse_tof,
//               tracks the T0->T1 sequence with timeout, queues records.
// Revision    : 1.0 - initial release
// ============================================================================
module trigger_event_stamper
  import trigger_event_stamper_pkg::*;
#(
  parameter int FIFO_DEPTH     = 16,
  parameter int TS_WIDTH       = 48,
  parameter int TIMEOUT_CYCLES = 125000000
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          enable,
  input  logic                          trigger0,
  input  logic                          trigger1,
  input  logic [31:0]                   pulse_tof,
  trigger_event_stamper_if.master       evt,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [15:0]                   overflow_cnt,
  output logic [1:0]                    seq_state,
  output logic                          seq_done
);

  localparam int                  c_REC_W    = rec_width(TS_WIDTH);
  localparam int                  c_TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_TMO_W-1:0]  c_TMO_LAST = c_TMO_W'(TIMEOUT_CYCLES - 1);

  logic               r_trig0_d;
  logic               r_trig1_d;
  logic [TS_WIDTH-1:0] r_ts;
  logic [15:0]        r_ovf;
  logic [c_TMO_W-1:0] r_tmo_cnt;
  logic [c_TMO_W-1:0] w_tmo_next;
  seq_state_t         r_state;
  seq_state_t         w_state_next;
  logic               w_rise0;
  logic               w_rise1;
  logic               w_edge;
  logic               w_tmo_push;
  logic               w_push;
  logic               w_full;
  logic               w_empty;
  logic [1:0]         w_src;
  logic [c_REC_W-1:0] w_wr_rec;
  logic [c_REC_W-1:0] w_rd_rec;

  assign w_rise0 = trigger0 & ~r_trig0_d;
  assign w_rise1 = trigger1 & ~r_trig1_d;
  assign w_edge  = enable & (w_rise0 | w_rise1);

  // History keeps sampling while disarmed so a level already high at arm is not an edge
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_trig0_d <= 1'b0;
      r_trig1_d <= 1'b0;
    end else begin
      r_trig0_d <= trigger0;
      r_trig1_d <= trigger1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= SEQ_DISARMED;
      r_tmo_cnt <= '0;
    end else begin
      r_state   <= w_state_next;
      r_tmo_cnt <= w_tmo_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_tmo_next   = r_tmo_cnt;
    w_tmo_push   = 1'b0;
    if (!enable) begin
      w_state_next = SEQ_DISARMED;
      w_tmo_next   = '0;
    end else begin
      unique case (r_state)
        SEQ_DISARMED: w_state_next = SEQ_WAIT_T0;
        SEQ_WAIT_T0: begin
          if (w_rise0 && w_rise1) begin
            w_state_next = SEQ_COMPLETE;
          end else if (w_rise0) begin
            w_state_next = SEQ_WAIT_T1;
            // Counter holds cycles elapsed since the T0 edge cycle
            w_tmo_next   = c_TMO_W'(1);
          end
        end
        SEQ_WAIT_T1: begin
          if (w_rise1) begin
            w_state_next = SEQ_COMPLETE;
          end else if (r_tmo_cnt == c_TMO_LAST) begin
            w_tmo_push   = 1'b1;
            w_state_next = SEQ_COMPLETE;
          end else begin
            w_tmo_next   = r_tmo_cnt + c_TMO_W'(1);
          end
        end
        SEQ_COMPLETE: w_state_next = SEQ_COMPLETE;
        default:      w_state_next = SEQ_DISARMED;
      endcase
    end
  end

  // An edge record takes the single push slot over a coincident timeout record
  always_comb begin
    w_src = EVT_SRC_TMO;
    if (w_rise0 && w_rise1) begin
      w_src = EVT_SRC_BOTH;
    end else if (w_rise0) begin
      w_src = EVT_SRC_T0;
    end else if (w_rise1) begin
      w_src = EVT_SRC_T1;
    end
  end

  assign w_push   = w_edge | w_tmo_push;
  assign w_wr_rec = {w_src, r_ts, pulse_tof};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ts  <= '0;
      r_ovf <= '0;
    end else if (!enable) begin
      r_ts  <= '0;
      r_ovf <= '0;
    end else begin
      r_ts <= r_ts + TS_WIDTH'(1);
      if (w_push && w_full && (r_ovf != 16'hFFFF)) begin
        r_ovf <= r_ovf + 16'd1;
      end
    end
  end

  evt_sync_fifo #(
    .WIDTH (c_REC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .flush   (~enable),
    .push    (w_push),
    .wr_data (w_wr_rec),
    .full    (w_full),
    .pop     (evt.evt_ready),
    .rd_data (w_rd_rec),
    .empty   (w_empty),
    .level   (fifo_level)
  );

  assign evt.evt_valid = ~w_empty;
  assign {evt.evt_src, evt.evt_ts, evt.evt_tof} = w_rd_rec;
  assign overflow_cnt  = r_ovf;
  assign seq_state     = r_state;
  assign seq_done      = (r_state != SEQ_COMPLETE) && (w_state_next == SEQ_COMPLETE);

endmodule
`default_nettype wire

// File: tb/tb_trigger_event_stamper.sv
`default_nettype none
// ============================================================================
// Module      : tb_trigger_event_stamper
// Description : Vector table, directed corner sequences and randomized
//               backpressure run against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_trigger_event_stamper;

  localparam int DEPTH = 4;
  localparam int TSW   = 12;
  localparam int TMO   = 300;

  typedef struct packed {
    logic        en;
    logic        t0;
    logic        t1;
    logic        rdy;
    logic [31:0] tof;
    logic        e_valid;
    logic [2:0]  e_level;
    logic [1:0]  e_state;
    logic        e_done;
    logic [1:0]  e_src;
    logic [11:0] e_ts;
    logic [31:0] e_tof;
  } vec_t;

  logic        clk = 1'b0;
  logic        resetn;
  logic        enable;
  logic        trigger0;
  logic        trigger1;
  logic [31:0] pulse_tof;
  logic [2:0]  fifo_level;
  logic [15:0] overflow_cnt;
  logic [1:0]  seq_state;
  logic        seq_done;
  logic [45:0] head;
  logic [22:0] ctl;
  int          total = 0;
  int          bad   = 0;

  trigger_event_stamper_if #(.TS_WIDTH(TSW)) evt_if ();

  trigger_event_stamper #(
    .FIFO_DEPTH     (DEPTH),
    .TS_WIDTH       (TSW),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .enable       (enable),
    .trigger0     (trigger0),
    .trigger1     (trigger1),
    .pulse_tof    (pulse_tof),
    .evt          (evt_if),
    .fifo_level   (fifo_level),
    .overflow_cnt (overflow_cnt),
    .seq_state    (seq_state),
    .seq_done     (seq_done)
  );

  always #5 clk = ~clk;

  assign head = {evt_if.evt_src, evt_if.evt_ts, evt_if.evt_tof};
  assign ctl  = {evt_if.evt_valid, fifo_level, seq_state, seq_done, overflow_cnt};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic disarm();
    enable           = 1'b0;
    trigger0         = 1'b0;
    trigger1         = 1'b0;
    evt_if.evt_ready = 1'b0;
    tick();
    tick();
  endtask

  task automatic pop_check(input string name, input logic [1:0] src, input logic [11:0] ts,
                           input logic [31:0] tof);
    evt_if.evt_ready = 1'b1;
    @(negedge clk);
    check({name, "_valid"}, evt_if.evt_valid, 1'b1);
    check({name, "_rec"}, head, {src, ts, tof});
    tick();
    evt_if.evt_ready = 1'b0;
  endtask

  function automatic vec_t mk(input logic en, input logic t0, input logic t1, input logic rdy,
                              input logic [31:0] tof, input logic v, input logic [2:0] lvl,
                              input logic [1:0] st, input logic dn, input logic [1:0] src,
                              input logic [11:0] ts, input logic [31:0] etof);
    vec_t r;
    r.en = en;  r.t0 = t0;  r.t1 = t1;  r.rdy = rdy;  r.tof = tof;
    r.e_valid = v;  r.e_level = lvl;  r.e_state = st;  r.e_done = dn;
    r.e_src = src;  r.e_ts = ts;  r.e_tof = etof;
    return r;
  endfunction

  initial begin
    vec_t        tbl [14];
    logic [45:0] q [$];
    logic [45:0] rec;
    logic [11:0] ts_m;
    logic [31:0] tofv;
    logic [15:0] m_ovf;
    logic        t0v, t1v, rdy, p0, p1, r0, r1, done_m, tmo_m, full;
    logic        armed, waiting_t1, complete;
    int          done_cnt, cyc, t0_cyc, popped;

    resetn = 1'b0;  enable = 1'b0;  trigger0 = 1'b0;  trigger1 = 1'b0;
    pulse_tof = '0;  evt_if.evt_ready = 1'b0;

    //            en t0 t1 rdy tof   | v lvl st dn src ts tof
    tbl[0]  = mk(0, 0, 0, 0, 32'h0,  0, 0, 0, 0, 0, 0, 32'h0);
    tbl[1]  = mk(1, 0, 0, 0, 32'h0,  0, 0, 0, 0, 0, 0, 32'h0);
    tbl[2]  = mk(1, 0, 0, 0, 32'h0,  0, 0, 1, 0, 0, 0, 32'h0);
    tbl[3]  = mk(1, 1, 1, 0, 32'hAA, 0, 0, 1, 1, 0, 0, 32'h0);
    tbl[4]  = mk(1, 1, 1, 0, 32'h0,  1, 1, 3, 0, 3, 2, 32'hAA);
    tbl[5]  = mk(1, 0, 0, 1, 32'h0,  1, 1, 3, 0, 3, 2, 32'hAA);
    tbl[6]  = mk(1, 0, 0, 1, 32'h0,  0, 0, 3, 0, 3, 2, 32'hAA);
    tbl[7]  = mk(1, 0, 1, 0, 32'h55, 0, 0, 3, 0, 3, 2, 32'hAA);
    tbl[8]  = mk(1, 0, 1, 0, 32'h0,  1, 1, 3, 0, 2, 6, 32'h55);
    tbl[9]  = mk(0, 1, 1, 0, 32'h0,  1, 1, 3, 0, 2, 6, 32'h55);
    tbl[10] = mk(0, 1, 1, 0, 32'h0,  0, 0, 0, 0, 0, 0, 32'h0);
    tbl[11] = mk(1, 1, 1, 0, 32'h0,  0, 0, 0, 0, 0, 0, 32'h0);
    tbl[12] = mk(1, 1, 1, 0, 32'h0,  0, 0, 1, 0, 0, 0, 32'h0);
    tbl[13] = mk(1, 1, 1, 0, 32'h0,  0, 0, 1, 0, 0, 0, 32'h0);

    repeat (2) @(posedge clk);
    #1;
    check("reset_ctl", ctl, 23'h0);
    check("reset_data", head, 46'h0);
    @(negedge clk);
    resetn = 1'b1;
    tick();

    for (int i = 0; i < 14; i++) begin
      enable = tbl[i].en;  trigger0 = tbl[i].t0;  trigger1 = tbl[i].t1;
      pulse_tof = tbl[i].tof;  evt_if.evt_ready = tbl[i].rdy;
      @(negedge clk);
      check($sformatf("vec%0d_ctl", i), ctl,
            {tbl[i].e_valid, tbl[i].e_level, tbl[i].e_state, tbl[i].e_done, 16'h0});
      check($sformatf("vec%0d_data", i), head, {tbl[i].e_src, tbl[i].e_ts, tbl[i].e_tof});
      tick();
    end

    // T0 at ts=100, T1 at ts=350
    disarm();
    enable = 1'b1;  pulse_tof = 32'h1234;  done_cnt = 0;
    for (int t = 0; t <= 360; t++) begin
      trigger0 = (t >= 100);
      trigger1 = (t >= 350);
      @(negedge clk);
      if (seq_done) done_cnt++;
      if (t == 350) check("seq_done_at_350", seq_done, 1'b1);
      tick();
    end
    check("seq_done_count", done_cnt, 1);
    check("seq_end_ctl", ctl, {1'b1, 3'd2, 2'd3, 1'b0, 16'd0});
    pop_check("seq_rec0", 2'b01, 12'd100, 32'h1234);
    pop_check("seq_rec1", 2'b10, 12'd350, 32'h1234);

    // Timeout: T0 at ts=10, no T1, timeout record at ts=10+TMO-1
    disarm();
    enable = 1'b1;  done_cnt = 0;
    for (int t = 0; t <= 320; t++) begin
      trigger0  = (t >= 10);
      pulse_tof = 32'hC000_0000 + 32'(t);
      @(negedge clk);
      if (seq_done) done_cnt++;
      if (t == 309) check("tmo_done_at_309", seq_done, 1'b1);
      tick();
    end
    check("tmo_done_count", done_cnt, 1);
    check("tmo_end_ctl", ctl, {1'b1, 3'd2, 2'd3, 1'b0, 16'd0});
    pop_check("tmo_rec0", 2'b01, 12'd10, 32'hC000_000A);
    pop_check("tmo_rec1", 2'b00, 12'd309, 32'hC000_0135);

    // Overflow: six T0 edges into a 4-deep FIFO with no consumer
    disarm();
    enable = 1'b1;  pulse_tof = '0;
    for (int t = 0; t <= 15; t++) begin
      trigger0 = (t >= 2 && t <= 12 && (t % 2 == 0));
      tick();
    end
    check("ovf_full_ctl", ctl, {1'b1, 3'd4, 2'd2, 1'b0, 16'd2});
    trigger1 = 1'b1;  evt_if.evt_ready = 1'b1;
    @(negedge clk);
    check("ovf_head_before_pop", head, {2'b01, 12'd2, 32'd0});
    check("ovf_done_t1", seq_done, 1'b1);
    tick();
    evt_if.evt_ready = 1'b0;
    check("ovf_pushpop_ctl", ctl, {1'b1, 3'd3, 2'd3, 1'b0, 16'd3});
    @(negedge clk);
    check("ovf_head_after_pop", head, {2'b01, 12'd4, 32'd0});
    tick();

    // Disarm with three queued records while waiting for T1
    disarm();
    enable = 1'b1;
    for (int t = 0; t <= 7; t++) begin
      trigger0 = (t == 2 || t == 4 || t == 6);
      tick();
    end
    check("dis_pre_ctl", ctl, {1'b1, 3'd3, 2'd2, 1'b0, 16'd0});
    enable = 1'b0;
    tick();
    check("dis_post_ctl", ctl, 23'h0);
    enable = 1'b1;  pulse_tof = 32'hD15A;
    for (int t = 0; t <= 4; t++) begin
      trigger0 = (t == 3);
      tick();
    end
    pop_check("dis_ts_restart", 2'b01, 12'd3, 32'hD15A);

    // Asynchronous reset in the middle of a cycle
    for (int t = 0; t <= 5; t++) begin
      trigger0 = (t == 2 || t == 4);
      tick();
    end
    #2;
    resetn = 1'b0;
    #1;
    check("areset_ctl", ctl, 23'h0);
    check("areset_data", head, 46'h0);
    @(negedge clk);
    enable = 1'b0;
    resetn = 1'b1;
    tick();

    // Randomized triggers and backpressure against the reference model
    disarm();
    enable = 1'b1;
    q.delete();
    m_ovf = '0;  ts_m = '0;  p0 = 1'b0;  p1 = 1'b0;
    armed = 1'b0;  waiting_t1 = 1'b0;  complete = 1'b0;
    cyc = 0;  t0_cyc = 0;  popped = 0;
    while (popped < 100 && cyc < 5000) begin
      t0v  = ($urandom_range(3) == 0);
      t1v  = ($urandom_range(4) == 0);
      rdy  = 1'($urandom_range(1));
      tofv = $urandom;
      trigger0 = t0v;  trigger1 = t1v;  pulse_tof = tofv;  evt_if.evt_ready = rdy;
      @(negedge clk);
      check("rnd_valid", evt_if.evt_valid, q.size() != 0);
      check("rnd_level", fifo_level, q.size());
      check("rnd_ovf", overflow_cnt, m_ovf);
      if (q.size() != 0) check("rnd_head", head, q[0]);

      r0 = t0v && !p0;
      r1 = t1v && !p1;
      done_m = 1'b0;
      tmo_m  = 1'b0;
      if (!armed) begin
        armed = 1'b1;
      end else if (!complete) begin
        if (!waiting_t1) begin
          if (r0 && r1) begin
            complete = 1'b1;  done_m = 1'b1;
          end else if (r0) begin
            waiting_t1 = 1'b1;  t0_cyc = cyc;
          end
        end else if (r1) begin
          complete = 1'b1;  done_m = 1'b1;
        end else if (cyc - t0_cyc == TMO - 1) begin
          complete = 1'b1;  done_m = 1'b1;  tmo_m = 1'b1;
        end
      end
      check("rnd_done", seq_done, done_m);

      rec  = {((r0 || r1) ? {r1, r0} : 2'b00), ts_m, tofv};
      full = (q.size() == DEPTH);
      if (rdy && q.size() != 0) begin
        void'(q.pop_front());
        popped++;
      end
      if (r0 || r1 || tmo_m) begin
        if (full) begin
          if (m_ovf != 16'hFFFF) m_ovf++;
        end else begin
          q.push_back(rec);
        end
      end
      p0 = t0v;  p1 = t1v;
      ts_m++;
      cyc++;
      tick();
    end
    check("rnd_drained_100", popped >= 100, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
